// File: rtl/serial_arith_pkg.sv
// Shared state encodings for the bit-serial arithmetic family (subtractor now,
// adder/multiplier later).
package serial_arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_sub_bit.sv
// One-bit full subtractor: d = x - y - bin, with borrow-out.
module full_sub_bit (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor, LSB first, one borrow flop, start/busy/done handshake.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             borrow
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state_r;
  logic [WIDTH-1:0] a_sr_r;
  logic [WIDTH-1:0] b_sr_r;
  logic [WIDTH-1:0] res_sr_r;
  logic [CNT_W-1:0] count_r;
  logic             br_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] diff_r;
  logic             borrow_r;
  logic             d_s;
  logic             bout_s;
  logic             accept_s;
`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb_r;
  logic             b_msb_r;
  logic             ovf_r;
`endif

  full_sub_bit u_bit (
    .x    (a_sr_r[0]),
    .y    (b_sr_r[0]),
    .bin  (br_r),
    .d    (d_s),
    .bout (bout_s)
  );

  assign accept_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));

  // FSM, datapath shift registers and registered result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      a_sr_r   <= '0;
      b_sr_r   <= '0;
      res_sr_r <= '0;
      count_r  <= '0;
      br_r     <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      diff_r   <= '0;
      borrow_r <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_r  <= 1'b0;
      b_msb_r  <= 1'b0;
      ovf_r    <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          done_r <= 1'b0;
          if (accept_s) begin
            a_sr_r  <= a;
            b_sr_r  <= b;
            br_r    <= 1'b0;
            count_r <= '0;
            busy_r  <= 1'b1;
            state_r <= ST_SHIFT;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_r <= a[WIDTH-1];
            b_msb_r <= b[WIDTH-1];
`endif
          end else begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          a_sr_r   <= {1'b0, a_sr_r[WIDTH-1:1]};
          b_sr_r   <= {1'b0, b_sr_r[WIDTH-1:1]};
          res_sr_r <= {d_s, res_sr_r[WIDTH-1:1]};
          br_r     <= bout_s;
          count_r  <= count_r + CNT_W'(1);
          // The final bit is still combinational here, so the result is
          // assembled from the live step output rather than res_sr_r.
          if (count_r == LAST_CNT) begin
            diff_r   <= {d_s, res_sr_r[WIDTH-1:1]};
            borrow_r <= bout_s;
            busy_r   <= 1'b0;
            done_r   <= 1'b1;
            state_r  <= ST_DONE;
`ifdef SERIAL_SUB_OVF_EN
            ovf_r    <= (a_msb_r ^ b_msb_r) & (a_msb_r ^ d_s);
`endif
          end else begin
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
            state_r <= ST_SHIFT;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign diff   = diff_r;
  assign borrow = borrow_r;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf    = ovf_r;
`endif

endmodule

// File: tb/tb_serial_sub.sv
// Directed + random self-checking bench for serial_sub (WIDTH=8).
module tb_serial_sub;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf;
`endif

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  serial_sub #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (op_a),
    .b      (op_b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
`ifdef SERIAL_SUB_OVF_EN
    .ovf    (ovf),
`endif
    .borrow (borrow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) begin
      passes++;
    end else begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for done with a bounded budget; lat = edges after the accept edge.
  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    check("done_seen", {31'd0, done}, 32'd1);
  endtask

  // Accepts one op at the next edge; returns with start low, just after accept.
  task automatic issue(input logic [7:0] xa, input logic [7:0] xb);
    start = 1'b1;
    op_a  = xa;
    op_b  = xb;
    step();
    start = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [7:0] xa, input logic [7:0] xb,
                        input logic [7:0] ed, input logic eb);
    int lat;
    issue(xa, xb);
    wait_done(lat);
    check({tag, "_lat"}, lat, 32'd8);
    check({tag, "_diff"}, {24'd0, diff}, {24'd0, ed});
    check({tag, "_borrow"}, {31'd0, borrow}, {31'd0, eb});
  endtask

  initial begin
    int lat;
    int seen;
    logic [7:0] ra;
    logic [7:0] rb;
    logic [8:0] exp9;

    rst_n = 1'b0;
    start = 1'b1;
    op_a  = 8'h12;
    op_b  = 8'h34;
    repeat (3) step();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_diff", {24'd0, diff}, 32'd0);
    check("rst_borrow", {31'd0, borrow}, 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
    start = 1'b0;
    rst_n = 1'b1;
    step();

    run_op("basic", 8'h5A, 8'h23, 8'h37, 1'b0);
    check("done_pulse", {31'd0, done}, 32'd1);
    step();
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("diff_held", {24'd0, diff}, 32'h37);
    step();
    run_op("neg", 8'h10, 8'h20, 8'hF0, 1'b1);
    step();
    run_op("zero_ff", 8'h00, 8'hFF, 8'h01, 1'b1);
    step();
    run_op("equal", 8'hAA, 8'hAA, 8'h00, 1'b0);
    step();

    // start mid-SHIFT with new operands must be ignored
    issue(8'hC3, 8'h3C);
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    step(); step();
    start = 1'b1; op_a = 8'h01; op_b = 8'h02;
    step();
    start = 1'b0; op_a = 8'hFF; op_b = 8'hFF;
    wait_done(lat);
    check("ignore_lat", lat, 32'd5);
    check("ignore_diff", {24'd0, diff}, 32'h87);
    check("ignore_borrow", {31'd0, borrow}, 32'd0);

    // back-to-back: start during the done cycle
    issue(8'h10, 8'h20);
    check("b2b_busy", {31'd0, busy}, 32'd1);
    wait_done(lat);
    check("b2b_lat", lat, 32'd8);
    check("b2b_diff", {24'd0, diff}, 32'hF0);

    // reset in the middle of SHIFT aborts the op
    step();
    issue(8'h77, 8'h11);
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_diff", {24'd0, diff}, 32'd0);
    check("abort_borrow", {31'd0, borrow}, 32'd0);
    step();
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      step();
      if (done === 1'b1) seen++;
    end
    check("abort_no_done", seen, 32'd0);
    run_op("after_abort", 8'h99, 8'h11, 8'h88, 1'b0);
    step();

`ifdef SERIAL_SUB_OVF_EN
    run_op("ovf1", 8'h80, 8'h01, 8'h7F, 1'b0);
    check("ovf1_ovf", {31'd0, ovf}, 32'd1);
    step();
    run_op("ovf2", 8'h7F, 8'hFF, 8'h80, 1'b1);
    check("ovf2_ovf", {31'd0, ovf}, 32'd1);
    step();
    run_op("ovf3", 8'h05, 8'h03, 8'h02, 1'b0);
    check("ovf3_ovf", {31'd0, ovf}, 32'd0);
    step();
`endif

    // random scoreboard against a 9-bit reference subtraction
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      exp9 = {1'b0, ra} - {1'b0, rb};
      issue(ra, rb);
      wait_done(lat);
      check("rand", {23'd0, borrow, diff}, {23'd0, exp9});
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
